// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port (WE3/A3/WD3) among N_REQ requesters, round-robin with locked bursts.
// Latency: a handshake in cycle t appears on WE3/A3/WD3/grant_id in cycle t+1; one write per cycle sustained.
// Backpressure: req_ready is one-hot-or-zero, combinational from req_valid and state; losers simply wait.
module regfile_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       WE3,
  output logic [ADDR_W-1:0]          A3,
  output logic [DATA_W-1:0]          WD3,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     owner;
  logic [CW-1:0]      beat_cnt;

  logic [IDW-1:0]     win;
  logic               found;
  logic [IDW-1:0]     src;
  logic [IDW-1:0]     next_ptr;
  logic               xfer;
  logic               src_lock;
  logic [ADDR_W-1:0]  src_addr;
  logic [DATA_W-1:0]  src_data;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset) begin
      if (state == LOCKED) req_ready[owner] = req_valid[owner];
      else                 req_ready[win]   = found;
    end
  end

  assign src      = (state == LOCKED) ? owner : win;
  assign next_ptr = (src == IDW'(N_REQ - 1)) ? '0 : src + IDW'(1);
  assign xfer     = |(req_valid & req_ready);
  assign src_lock = req_lock[src];
  assign src_addr = req_addr[src*ADDR_W +: ADDR_W];
  assign src_data = req_data[src*DATA_W +: DATA_W];
  assign busy     = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      grant_id <= '0;
    end else begin
      WE3 <= xfer;
      if (xfer) begin
        A3       <= src_addr;
        WD3      <= src_data;
        grant_id <= src;
      end
      case (state)
        ARB: begin
          if (xfer) begin
            if (src_lock && (MAX_BURST > 1)) begin
              owner    <= src;
              beat_cnt <= CW'(1);
              state    <= LOCKED;
            end else begin
              rr_ptr <= next_ptr;
            end
          end
        end
        LOCKED: begin
          // A non-transfer here means the owner dropped valid: release without granting.
          if (xfer && src_lock && (beat_cnt + CW'(1) != CW'(MAX_BURST))) begin
            beat_cnt <= beat_cnt + CW'(1);
          end else begin
            state    <= ARB;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a transaction-level reference model.
module tb_regfile_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            WE3;
  logic [AW-1:0]   A3;
  logic [DW-1:0]   WD3;
  logic [1:0]      grant_id;
  logic            busy;

  regfile_wr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: rr pointer, burst owner (-1 = none), beats taken, expected outputs
  int            m_rr, m_owner, m_beats;
  logic          e_we;
  logic [AW-1:0] e_a3;
  logic [DW-1:0] e_wd;
  int            e_gid;
  logic [N-1:0]  last_rdy, obs_rdy;
  logic          obs_we, obs_busy;
  logic [DW-1:0] regs [8];

  always @(posedge clk) if (WE3) regs[A3] <= WD3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst) return r;
    if (m_owner >= 0) begin
      r[m_owner] = req_valid[m_owner];
      return r;
    end
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) begin
        r[(m_rr + k) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_edge(input logic [N-1:0] er);
    int w;
    w = 0;
    if (rst) begin
      m_rr = 0; m_owner = -1; m_beats = 0;
      e_we = 1'b0; e_a3 = '0; e_wd = '0; e_gid = 0;
      return;
    end
    if (er != '0) begin
      for (int k = 0; k < N; k++) if (er[k]) w = k;
      e_we = 1'b1;
      e_a3 = req_addr[w*AW +: AW];
      e_wd = req_data[w*DW +: DW];
      e_gid = w;
      if (m_owner < 0) begin
        if (req_lock[w] && MB > 1) begin m_owner = w; m_beats = 1; end
        else m_rr = (w + 1) % N;
      end else begin
        m_beats++;
        if (!req_lock[w] || m_beats == MB) begin
          m_rr = (m_owner + 1) % N; m_owner = -1; m_beats = 0;
        end
      end
    end else begin
      e_we = 1'b0;
      if (m_owner >= 0 && !req_valid[m_owner]) begin
        m_rr = (m_owner + 1) % N; m_owner = -1; m_beats = 0;
      end
    end
  endtask

  // one clock: check combinational and registered outputs, then advance the model at the edge
  task automatic cycle();
    logic [N-1:0] er;
    #3;
    er = exp_ready();
    obs_rdy = req_ready; obs_we = WE3; obs_busy = busy;
    chk("ready", {28'd0, req_ready}, {28'd0, er});
    chk("we", {31'd0, WE3}, {31'd0, e_we});
    chk("busy", {31'd0, busy}, {31'd0, (m_owner >= 0)});
    if (e_we) begin
      chk("a3", {29'd0, A3}, {29'd0, e_a3});
      chk("wd3", {24'd0, WD3}, {24'd0, e_wd});
      chk("gid", {30'd0, grant_id}, e_gid);
    end
    @(posedge clk);
    model_edge(er);
    last_rdy = er;
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input int a, input int d);
    req_valid[i] = v;
    req_lock[i]  = l;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '0; req_lock = '0;
    for (int c = 0; c < n; c++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;
    last_rdy = '0;
    @(posedge clk);
    m_rr = 0; m_owner = -1; m_beats = 0; e_we = 1'b0; e_a3 = '0; e_wd = '0; e_gid = 0;
    #1;

    // reset held with every requester valid
    req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("t1_rdy", {28'd0, obs_rdy}, 0);
      chk("t1_we", {31'd0, WE3}, 0);
      chk("t1_a3wd", {21'd0, A3, WD3}, 0);
      chk("t1_busy", {31'd0, busy}, 0);
    end
    rst = 1'b0; req_valid = '0;

    // single requester
    set_req(2, 1'b1, 1'b0, 5, 8'hA5);
    cycle();
    chk("t2_rdy", {28'd0, obs_rdy}, 32'h4);
    chk("t2_out", {20'd0, WE3, A3, WD3}, {20'd0, 1'b1, 3'd5, 8'hA5});
    chk("t2_gid", {30'd0, grant_id}, 2);
    req_valid = '0;
    cycle();
    chk("t2_reg5", {24'd0, regs[5]}, 32'hA5);

    // all valid, no lock: plain rotation
    do_reset(1);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i, 8'h10 + i);
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c > 0) chk("t3_we", {31'd0, obs_we}, 1);
      chk("t3_gid", {30'd0, grant_id}, c % 4);
    end

    // locked burst capped at MAX_BURST
    do_reset(1);
    set_req(1, 1'b1, 1'b1, 3, 8'h31);
    set_req(3, 1'b1, 1'b0, 6, 8'h36);
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("t4_rdy", {28'd0, obs_rdy}, 32'h2);
      if (c > 0) chk("t4_busy", {31'd0, obs_busy}, 1);
    end
    cycle();
    chk("t4_next", {28'd0, obs_rdy}, 32'h8);
    chk("t4_nbusy", {31'd0, obs_busy}, 0);
    req_valid = '0;
    cycle();

    // owner drops valid mid-burst
    do_reset(1);
    set_req(0, 1'b1, 1'b1, 1, 8'h01);
    set_req(2, 1'b1, 1'b0, 2, 8'h02);
    cycle(); cycle();
    req_valid[0] = 1'b0;
    cycle();
    chk("t5_idle", {28'd0, obs_rdy}, 0);
    cycle();
    chk("t5_rdy", {28'd0, obs_rdy}, 32'h4);
    chk("t5_busy", {31'd0, obs_busy}, 0);
    req_valid = '0;
    cycle();

    // reset right after a locked beat
    do_reset(1);
    set_req(3, 1'b1, 1'b1, 7, 8'h77);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i, 8'h50 + i);
    cycle();
    chk("t6_we", {31'd0, obs_we}, 0);
    chk("t6_busy", {31'd0, obs_busy}, 0);
    chk("t6_rdy", {28'd0, obs_rdy}, 32'h1);

    // randomized traffic; pending requests hold their payload until accepted
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_rdy[i])) begin
          req_valid[i] = ($urandom_range(2) != 0);
          req_lock[i]  = ($urandom_range(1) != 0);
          req_addr[i*AW +: AW] = AW'($urandom);
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
